// File: rtl/dice_scorer.sv
// Score keeper for the electronic dice: captures the throw on each button release,
// validates it, accumulates score and roll count, flags doubles and ends the game at TARGET.
module dice_scorer #(
  parameter int TARGET  = 30,
  parameter int SCORE_W = 6,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               button,
  input  logic [2:0]         throw,
  input  logic               new_game,
  output logic               roll_valid,
  output logic [2:0]         roll_value,
  output logic               illegal,
  output logic               double_flag,
  output logic [SCORE_W-1:0] score,
  output logic [COUNT_W-1:0] roll_count,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, ROLLING, DONE} state_t;

  localparam logic [SCORE_W-1:0] TARGET_S = SCORE_W'(TARGET);

  state_t             state_reg, state_next;
  logic               button_q;
  logic [2:0]         value_reg, value_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic               prev_reg, prev_next;
  logic               valid_reg, valid_next;
  logic               illegal_reg, illegal_next;
  logic               double_reg, double_next;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] sat_sum;
  logic               release_edge;
  logic               legal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      button_q    <= 1'b0;
      value_reg   <= '0;
      score_reg   <= '0;
      count_reg   <= '0;
      prev_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      double_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      button_q    <= button;
      value_reg   <= value_next;
      score_reg   <= score_next;
      count_reg   <= count_next;
      prev_reg    <= prev_next;
      valid_reg   <= valid_next;
      illegal_reg <= illegal_next;
      double_reg  <= double_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    value_next   = value_reg;
    score_next   = score_reg;
    count_next   = count_reg;
    prev_next    = prev_reg;
    valid_next   = 1'b0;
    illegal_next = 1'b0;
    double_next  = 1'b0;
    release_edge = button_q & ~button;
    legal        = (throw != 3'd0) && (throw != 3'd7);
    sum          = {1'b0, score_reg} + {{(SCORE_W-2){1'b0}}, throw};
    sat_sum      = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];

    // A new game wins over anything else happening on the same edge
    if (new_game) begin
      value_next = '0;
      score_next = '0;
      count_next = '0;
      prev_next  = 1'b0;
      state_next = button ? ROLLING : IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (button) state_next = ROLLING;
        end
        ROLLING: begin
          if (release_edge) begin
            if (legal) begin
              valid_next  = 1'b1;
              double_next = prev_reg && (throw == value_reg);
              value_next  = throw;
              score_next  = sat_sum;
              count_next  = (&count_reg) ? count_reg : count_reg + COUNT_W'(1);
              prev_next   = 1'b1;
            end else begin
              illegal_next = 1'b1;
            end
            state_next = (score_next >= TARGET_S) ? DONE : IDLE;
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign roll_valid  = valid_reg;
  assign roll_value  = value_reg;
  assign illegal     = illegal_reg;
  assign double_flag = double_reg;
  assign score       = score_reg;
  assign roll_count  = count_reg;
  assign done        = (state_reg == DONE);

endmodule

// File: tb/tb_dice_scorer.sv
// Bench for dice_scorer: directed game scenarios with literal expectations, then
// random play, all checked every cycle against a behavioural game model.
module tb_dice_scorer;
  localparam int TARGET  = 30;
  localparam int SCORE_W = 6;
  localparam int COUNT_W = 4;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;
  localparam int COUNT_MAX = (1 << COUNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               button = 1'b0;
  logic [2:0]         throw = 3'd0;
  logic               new_game = 1'b0;
  logic               roll_valid, illegal, double_flag, done;
  logic [2:0]         roll_value;
  logic [SCORE_W-1:0] score;
  logic [COUNT_W-1:0] roll_count;

  dice_scorer #(.TARGET(TARGET), .SCORE_W(SCORE_W), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst(rst), .button(button), .throw(throw), .new_game(new_game),
    .roll_valid(roll_valid), .roll_value(roll_value), .illegal(illegal),
    .double_flag(double_flag), .score(score), .roll_count(roll_count), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // game model: what a player watching the board would expect
  int m_score, m_count, m_value;
  bit m_valid, m_illegal, m_double, m_done, m_has_prev, m_rolling, m_btn_q;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_score = 0; m_count = 0; m_value = 0;
    m_valid = 0; m_illegal = 0; m_double = 0; m_done = 0;
    m_has_prev = 0; m_rolling = 0; m_btn_q = 0;
  endtask

  task automatic model_edge();
    int t;
    bit released;
    t = int'(throw);
    released = m_btn_q && !button;
    m_valid = 0; m_illegal = 0; m_double = 0;
    if (new_game) begin
      m_score = 0; m_count = 0; m_value = 0; m_has_prev = 0; m_done = 0;
      m_rolling = button;
    end else if (m_done) begin
      m_done = 1;
    end else if (!m_rolling) begin
      m_rolling = button;
    end else if (released) begin
      m_rolling = 0;
      if (t >= 1 && t <= 6) begin
        m_double   = m_has_prev && (t == m_value);
        m_valid    = 1;
        m_value    = t;
        m_score    = (m_score + t > SCORE_MAX) ? SCORE_MAX : m_score + t;
        m_count    = (m_count + 1 > COUNT_MAX) ? COUNT_MAX : m_count + 1;
        m_has_prev = 1;
      end else begin
        m_illegal = 1;
      end
      if (m_score >= TARGET) m_done = 1;
    end
    m_btn_q = button;
  endtask

  // one clock: inputs set at negedge, model advanced at the posedge
  task automatic cyc(input bit b, input int t, input bit ng);
    @(negedge clk);
    button = b; throw = 3'(t); new_game = ng;
    @(posedge clk);
    if (rst) model_edge();
  endtask

  task automatic roll(input int t, input int presses);
    for (int i = 0; i < presses; i++) cyc(1'b1, 0, 1'b0);
    cyc(1'b0, t, 1'b0);
    #1;
  endtask

  task automatic pin(input string tag, input int v, input int il, input int d,
                     input int val, input int s, input int c, input int dn);
    chk({tag, ".roll_valid"}, int'(roll_valid), v);
    chk({tag, ".illegal"}, int'(illegal), il);
    chk({tag, ".double_flag"}, int'(double_flag), d);
    chk({tag, ".roll_value"}, int'(roll_value), val);
    chk({tag, ".score"}, int'(score), s);
    chk({tag, ".roll_count"}, int'(roll_count), c);
    chk({tag, ".done"}, int'(done), dn);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("roll_valid", int'(roll_valid), int'(m_valid));
      chk("illegal", int'(illegal), int'(m_illegal));
      chk("double_flag", int'(double_flag), int'(m_double));
      chk("roll_value", int'(roll_value), m_value);
      chk("score", int'(score), m_score);
      chk("roll_count", int'(roll_count), m_count);
      chk("done", int'(done), int'(m_done));
      if (roll_valid || illegal)
        $display("roll value=%0d valid=%0d illegal=%0d double=%0d score=%0d count=%0d done=%0d",
                 roll_value, roll_valid, illegal, double_flag, score, roll_count, done);
    end
  end

  initial begin
    int hold;
    model_reset();
    #1;
    pin("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    started = 1'b1;

    roll(4, 3); pin("first4", 1, 0, 0, 4, 4, 1, 0);
    roll(4, 2); pin("second4", 1, 0, 1, 4, 8, 2, 0);
    roll(2, 2); pin("third2", 1, 0, 0, 2, 10, 3, 0);
    roll(7, 2); pin("illegal7", 0, 1, 0, 2, 10, 3, 0);
    roll(0, 1); pin("illegal0", 0, 1, 0, 2, 10, 3, 0);
    roll(5, 1); pin("after_illegal5", 1, 0, 0, 5, 15, 4, 0);
    roll(6, 2); roll(6, 2); pin("score27", 1, 0, 1, 6, 27, 6, 0);
    roll(5, 2); pin("final5", 1, 0, 0, 5, 32, 7, 1);
    roll(6, 2); pin("done_ignores", 0, 0, 0, 5, 32, 7, 1);
    cyc(1'b0, 0, 1'b1); #1; pin("new_game", 0, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 0, 1'b0); cyc(1'b1, 0, 1'b0); cyc(1'b0, 3, 1'b1); #1;
    pin("ng_on_release", 0, 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 0, 1'b0);

    // asynchronous reset in the middle of a roll
    roll(6, 2); pin("pre_reset", 1, 0, 0, 6, 6, 1, 0);
    cyc(1'b1, 0, 1'b0); cyc(1'b1, 0, 1'b0);
    #2 rst = 1'b0;
    model_reset();
    #1; pin("async_reset", 0, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 0, 1'b0);
    @(negedge clk); button = 1'b0;
    rst = 1'b1;
    cyc(1'b0, 0, 1'b0); cyc(1'b0, 0, 1'b0); #1;
    pin("post_reset_release", 0, 0, 0, 0, 0, 0, 0);
    roll(6, 2); pin("post_reset_roll", 1, 0, 0, 6, 6, 1, 0);

    // random play
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      bit b;
      b = button;
      if (hold == 0) begin
        b = ~button;
        hold = $urandom_range(0, 4);
      end else hold--;
      if ($urandom_range(0, 399) == 0) begin
        @(negedge clk); #2 rst = 1'b0;
        model_reset();
        @(negedge clk); rst = 1'b1;
      end
      cyc(b, $urandom_range(0, 7), $urandom_range(0, 29) == 0);
    end
    cyc(1'b0, 0, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dice_scorer.md
Name: dice_scorer

Overview:
- Consumer end of the electronic-dice interface: sits downstream of the dice block, sharing its `clk` and `button` and taking its 3-bit `throw` output.
- Detects the end of each roll (button release) and captures the settled throw.
- Validates the throw, accumulates a game score, counts rolls and flags repeated values.
- Declares the game over when the score reaches a target; intended to drive the board LEDs / display logic.

Parameters:
- TARGET, 30, score at or above which the game ends; must be ≤ 2^SCORE_W − 1.
- SCORE_W, 6, width of the score accumulator.
- COUNT_W, 4, width of the roll counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- button  input  1  same roll button driven to the dice block; high = rolling. Already synchronous to clk.
- throw  input  3  dice output; legal values 1..6.
- new_game  input  1  synchronous clear of the game; level sampled each edge.
- roll_valid  output  1  one-cycle pulse: legal roll captured.
- roll_value  output  3  last legal captured throw.
- illegal  output  1  one-cycle pulse: captured throw was 0 or 7.
- double_flag  output  1  one-cycle pulse with roll_valid: value equals previous legal value.
- score  output  SCORE_W  running total of legal throws.
- roll_count  output  COUNT_W  number of legal rolls this game.
- done  output  1  game over, level.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; roll_value=0; score=0; roll_count=0; all pulses=0; done=0; button_q=0; prev-valid marker cleared. Reset mid-roll discards the roll.
- button_q is button registered one cycle; a release is button_q=1 and button=0 at an edge.
- State IDLE: button=1 → ROLLING. Otherwise stay.
- State ROLLING: stay while button=1. On a release edge, throw is sampled at that same edge and:
  - Legal throw (1..6):
    - roll_value ← throw, roll_valid ← 1.
    - score ← score + throw, saturating at 2^SCORE_W − 1; sum computed at SCORE_W+1 bits.
    - roll_count ← roll_count + 1, saturating at all-ones.
    - double_flag ← 1 if a previous legal roll exists this game and throw == roll_value.
  - Illegal throw (0 or 7): illegal ← 1; roll_value, score, roll_count and previous-roll history unchanged.
  - Next state: DONE if the new score ≥ TARGET, else IDLE.
- Latency: outputs update on the release edge. Pulses are high for exactly the following cycle and cleared on the next edge.
- State DONE:
  - done=1 (asserted on the same edge the final score is written).
  - button and throw ignored; score and roll_count hold.
  - Exit only via new_game or rst.
- new_game=1 (any state):
  - Next edge: score, roll_count, done and previous-roll history ← 0; roll_value ← 0; state ← IDLE if button=0, else ROLLING.
  - new_game has priority over a simultaneous release: that roll is discarded and no pulse is issued.
- Press shorter than one cycle between edges is not seen; no debouncing in this block.
- A release with no preceding press sampled (IDLE) produces nothing.
- Pulses never overlap: roll_valid and illegal are mutually exclusive; double_flag implies roll_valid.

Test Plan:
- Reset, press 3 cycles, throw=4, release → roll_valid one cycle, roll_value=4, score=4, roll_count=1, double_flag=0.
- Second roll released with throw=4 → roll_valid and double_flag both pulse, score=8, roll_count=2. Third roll with throw=2 → double_flag=0, score=10.
- Release with throw=7, then a roll with throw=0 → illegal pulses each time; score, roll_count and roll_value unchanged; next legal throw=5 gives double_flag=0 if the previous legal value was not 5.
- Score 27, release with throw=5 → score=32, done=1 same edge. Further press/release of throw=6 → no pulses, score stays 32.
- new_game asserted in DONE → score=0, roll_count=0, done=0. new_game asserted on a release edge with throw=3 → no roll_valid, score=0.
- rst driven low between edges while in ROLLING → outputs 0 immediately without a clock edge. After rst returns high and button is released, no pulse; the next full press/release with throw=6 gives score=6.
